// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its bench.
package seq_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HUNG  = 2'd3
   } seq_state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   // Instruction word layout: III M XXX DDDDDDDDD
   function automatic logic [WORD_W-1:0] enc_instr(input logic [2:0] op, input logic imm,
                                                   input logic [2:0] rx, input logic [8:0] d);
      return {op, imm, rx, d};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; drops pushes when full, ignores pops when empty.
module sync_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_empty;
   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_nxt;

   assign w_push      = push && !r_full;
   assign w_pop       = pop && !r_empty;
   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge Clock) begin
      if (w_push) r_mem[r_wp] <= wdata;
   end

   assign rdata = r_mem[r_rp];
   assign count = r_count;
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/instr_sequencer.sv
// Feeds buffered instruction words to the processor over DIN/Run, waits for Done,
// counts retired instructions and flags a Done timeout.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [WORD_W-1:0] WrData,
   input  logic              WrEn,
   input  logic              Enable,
   input  logic              Done,
   output logic [WORD_W-1:0] DIN,
   output logic              Run,
   output logic              Full,
   output logic              Empty,
   output logic [AW:0]       Count,
   output logic              Busy,
   output logic [15:0]       Retired,
   output logic              Err
);

   localparam int unsigned WCW = $clog2(TIMEOUT + 1);

   seq_state_t        r_state;
   logic [WORD_W-1:0] r_din;
   logic              r_run;
   logic              r_busy;
   logic [WCW-1:0]    r_wcnt;
   logic [15:0]       r_retired;
   logic              r_err;

   logic [WORD_W-1:0] w_head;
   logic              w_empty;
   logic              w_can_issue;
   logic              w_pop;
   logic [WCW-1:0]    w_wcnt_nxt;

   sync_fifo #(.W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .Clock  (Clock),
      .Resetn (Resetn),
      .push   (WrEn),
      .pop    (w_pop),
      .wdata  (WrData),
      .rdata  (w_head),
      .count  (Count),
      .full   (Full),
      .empty  (w_empty)
   );

   assign w_can_issue = Enable && !w_empty;
   assign w_pop       = w_can_issue && ((r_state == IDLE) || ((r_state == WAIT) && Done));
   assign w_wcnt_nxt  = r_wcnt + WCW'(1);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state   <= IDLE;
         r_din     <= '0;
         r_run     <= 1'b0;
         r_busy    <= 1'b0;
         r_wcnt    <= '0;
         r_retired <= '0;
         r_err     <= 1'b0;
      end else begin
         r_run <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_can_issue) begin
                  r_state <= ISSUE;
                  r_din   <= w_head;
                  r_run   <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_din <= '0;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
               r_wcnt  <= '0;
            end
            WAIT: begin
               if (Done) begin
                  r_retired <= r_retired + 16'd1;
                  if (w_can_issue) begin
                     r_state <= ISSUE;
                     r_din   <= w_head;
                     r_run   <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_din   <= '0;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_wcnt <= w_wcnt_nxt;
                  // Hung processor: park until reset, keeping DIN for inspection.
                  if (w_wcnt_nxt == WCW'(TIMEOUT)) begin
                     r_state <= HUNG;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end
            HUNG: begin
               r_state <= HUNG;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign DIN     = r_din;
   assign Run     = r_run;
   assign Busy    = r_busy;
   assign Retired = r_retired;
   assign Err     = r_err;
   assign Empty   = w_empty;

endmodule
